// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x3 telephone keypad scanner.
//   KEY_NONE / KEY_STAR / KEY_SHARP : special key codes
//   kp_state_e                      : debounce FSM states
//   key_map(row, col)               : physical position -> 4-bit key code
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam logic [3:0] KEY_NONE  = 4'hF;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_SHARP = 4'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    // Rows 0..2 hold 1-9 in reading order; row 3 is "* 0 #".
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_SHARP;
            endcase
        end else begin
            code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// -----------------------------------------------------------------------------
// keypad_col_scan
// Column scanner: synchronizes the rows, divides the clock down to one column
// slot per SCAN_DIV cycles, rotates the active-low column drive and collects
// the keys seen across one full col0..col2 frame.
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   row_in[3:0]   : raw keypad rows, active-low, asynchronous
//   col_out[2:0]  : column drive, active-low one-hot (col0 after reset)
//   frame_done    : one-cycle pulse after the tick that sampled col2
//   frame_none    : the finished frame contained zero pressed keys
//   frame_multi   : two or more keys seen in the finished frame
//   frame_code    : code of the single key (meaningful when neither flag set)
// Column settling needs the 2-flop synchronizer delay to fit inside one slot,
// so sampling is exact for SCAN_DIV >= 3.
// -----------------------------------------------------------------------------
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic       frame_done,
    output logic       frame_none,
    output logic       frame_multi,
    output logic [3:0] frame_code
);

    localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] div_cnt;
    logic          scan_tick;
    logic [1:0]    col_idx;
    // Key count so far in this frame, saturating at 2 (= "multi").
    logic [1:0]    acc_n;
    logic [3:0]    acc_code;

    logic [3:0]    hits;
    logic [1:0]    col_n;
    logic [3:0]    col_code;
    logic [1:0]    sum_n;
    logic [3:0]    sum_code;

    assign scan_tick = (div_cnt == DIV_LAST);

    always_comb begin
        hits     = ~row_s2;
        col_n    = 2'd0;
        col_code = KEY_NONE;
        for (int r = 0; r < 4; r++) begin
            if (hits[r]) begin
                if (col_n != 2'd2) col_n = col_n + 2'd1;
                col_code = key_map(2'(r), col_idx);
            end
        end
        // Merge this column into the running frame total.
        sum_n    = 2'd2;
        sum_code = acc_code;
        if (acc_n == 2'd0) begin
            sum_n    = col_n;
            sum_code = col_code;
        end else if (acc_n == 2'd1 && col_n == 2'd0) begin
            sum_n    = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1      <= 4'hF;
            row_s2      <= 4'hF;
            div_cnt     <= '0;
            col_idx     <= 2'd0;
            col_out     <= 3'b110;
            acc_n       <= 2'd0;
            acc_code    <= KEY_NONE;
            frame_done  <= 1'b0;
            frame_none  <= 1'b1;
            frame_multi <= 1'b0;
            frame_code  <= KEY_NONE;
        end else begin
            row_s1     <= row_in;
            row_s2     <= row_s1;
            frame_done <= 1'b0;
            if (scan_tick) begin
                div_cnt <= '0;
                if (col_idx == 2'd2) begin
                    col_idx     <= 2'd0;
                    col_out     <= 3'b110;
                    frame_done  <= 1'b1;
                    frame_none  <= (sum_n == 2'd0);
                    frame_multi <= (sum_n == 2'd2);
                    frame_code  <= sum_code;
                    acc_n       <= 2'd0;
                    acc_code    <= KEY_NONE;
                end else begin
                    col_idx  <= col_idx + 2'd1;
                    col_out  <= {col_out[1:0], 1'b1};
                    acc_n    <= sum_n;
                    acc_code <= sum_code;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans and debounces a 4x3 telephone keypad and presents the held key to the
// downstream tone converter.
// Ports
//   CLK        : system clock, rising edge
//   RST        : asynchronous active-low reset
//   ROW_IN     : keypad rows, active-low, asynchronous to CLK
//   COL_OUT    : column drive, active-low one-hot
//   B_out      : debounced key code (0-9, *=10, #=11, none=15)
//   KEY_VALID  : high while a debounced key is held
//   KEY_PRESS  : one-CLK pulse per newly accepted press
//   state_dbg  : current debounce FSM state (kp_state_e encoding)
// Output semantics: KEY_VALID is a level qualifying B_out; there is no ready
// and no backpressure -- the consumer samples B_out whenever KEY_VALID is
// high, and KEY_PRESS marks the first cycle of each new press.
// Option KEYPAD_STICKY_EN: after a release the last key stays on B_out with
// KEY_VALID high; only a debounced multi-key frame run clears it.
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 4000,
    parameter int DEB_FRAMES = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ROW_IN,
    output logic [2:0] COL_OUT,
    output logic [3:0] B_out,
    output logic       KEY_VALID,
    output logic       KEY_PRESS,
    output logic [1:0] state_dbg
);

    localparam int            CW       = $clog2(DEB_FRAMES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_FRAMES);

    logic       frame_done, frame_none, frame_multi;
    logic [3:0] frame_code;
    logic       frame_single, frame_match;

    kp_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    cand, cand_n;
    logic [3:0]    b_n;
    logic          valid_n, press_n;

    keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
        .clk         (CLK),
        .rst_n       (RST),
        .row_in      (ROW_IN),
        .col_out     (COL_OUT),
        .frame_done  (frame_done),
        .frame_none  (frame_none),
        .frame_multi (frame_multi),
        .frame_code  (frame_code)
    );

    assign frame_single = !frame_none && !frame_multi;
    assign frame_match  = frame_single && (frame_code == cand);
    assign cnt_inc      = cnt + CW'(1);
    assign state_dbg    = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= KEY_NONE;
            B_out     <= KEY_NONE;
            KEY_VALID <= 1'b0;
            KEY_PRESS <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            B_out     <= b_n;
            KEY_VALID <= valid_n;
            KEY_PRESS <= press_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        b_n     = B_out;
        valid_n = KEY_VALID;
        press_n = 1'b0;
        if (frame_done) begin
            unique case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (frame_single) begin
                        cand_n = frame_code;
                        if (DEB_FRAMES == 1) begin
                            state_n = PRESSED;
                            b_n     = frame_code;
                            valid_n = 1'b1;
                            press_n = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = CW'(1);
                        end
                    end
`ifdef KEYPAD_STICKY_EN
                    // In IDLE the counter tracks consecutive multi-key frames,
                    // the deliberate gesture that clears a sticky key.
                    else if (frame_multi) begin
                        if (cnt_inc == DEB_LAST) begin
                            b_n     = KEY_NONE;
                            valid_n = 1'b0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
`endif
                end
                DEBOUNCE: begin
                    if (frame_match) begin
                        if (cnt_inc == DEB_LAST) begin
                            state_n = PRESSED;
                            cnt_n   = '0;
                            b_n     = cand;
                            valid_n = 1'b1;
                            press_n = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if (frame_single) begin
                        cand_n = frame_code;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (!frame_match) begin
                        state_n = RELEASE;
                        cnt_n   = CW'(1);
                        if (DEB_FRAMES == 1) begin
                            state_n = IDLE;
                            cnt_n   = '0;
`ifdef KEYPAD_STICKY_EN
`else
                            b_n     = KEY_NONE;
                            valid_n = 1'b0;
`endif
                        end
                    end
                end
                RELEASE: begin
                    // A returning candidate is contact bounce: resume the
                    // press silently.
                    if (frame_match) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
`ifdef KEYPAD_STICKY_EN
`else
                        b_n     = KEY_NONE;
                        valid_n = 1'b0;
`endif
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Keypad scanner bench: a keypad contact model drives ROW_IN from a 12-bit
// pressed-key map and COL_OUT; a frame-level reference model predicts the
// column drive and debounced outputs every cycle.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV   = 4;
    localparam int DEB_FRAMES = 3;
    localparam int FRAME      = 3 * SCAN_DIV;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] ROW_IN;
    logic [2:0] COL_OUT;
    logic [3:0] B_out;
    logic       KEY_VALID;
    logic       KEY_PRESS;
    logic [1:0] state_dbg;

    // Pressed keys, bit index = row*3 + col.
    logic [11:0] keys = '0;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ROW_IN    (ROW_IN),
        .COL_OUT   (COL_OUT),
        .B_out     (B_out),
        .KEY_VALID (KEY_VALID),
        .KEY_PRESS (KEY_PRESS),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / keypad contacts ----------------
    always #5 CLK = ~CLK;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            ROW_IN[r] = 1'b1;
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !COL_OUT[c]) ROW_IN[r] = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_DEB, M_HELD, M_REL} mphase_t;
    int key_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    mphase_t     m_ph;
    int          m_cand, m_cnt, m_mcnt;
    logic [3:0]  exp_b;
    logic        exp_valid, exp_press;
    int          e;              // rising edges since reset release
    logic [11:0] hist [8];       // hist[i%8] = key map just before edge i+1
    int          acc_n, acc_code, fr_n, fr_code;
    bit          pend;
    logic [3:0]  exp_q [$];      // codes of presses the model has accepted
    int          press_cnt;
    bit          saw_low;

    function automatic logic [11:0] key_bit(input int code);
        logic [11:0] m = '0;
        for (int i = 0; i < 12; i++) if (key_tab[i] == code) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, e, $time);
        end
    endtask

    task automatic m_accept();
        m_ph      = M_HELD;
        exp_b     = 4'(m_cand);
        exp_valid = 1'b1;
        exp_press = 1'b1;
        exp_q.push_back(4'(m_cand));
    endtask

    task automatic m_drop();
        m_ph   = M_IDLE;
        m_mcnt = 0;
`ifndef KEYPAD_STICKY_EN
        exp_b     = 4'hF;
        exp_valid = 1'b0;
`endif
    endtask

    task automatic model_frame(input int nk, input int code);
        bit single, match;
        single = (nk == 1);
        match  = single && (code == m_cand);
        case (m_ph)
            M_IDLE: begin
                if (single) begin
                    m_cand = code;
                    m_cnt  = 1;
                    m_mcnt = 0;
                    if (m_cnt >= DEB_FRAMES) m_accept();
                    else m_ph = M_DEB;
                end else if (nk > 1) begin
`ifdef KEYPAD_STICKY_EN
                    m_mcnt++;
                    if (m_mcnt >= DEB_FRAMES) begin
                        exp_b = 4'hF; exp_valid = 1'b0; m_mcnt = 0;
                    end
`endif
                end else begin
                    m_mcnt = 0;
                end
            end
            M_DEB: begin
                if (match) begin
                    m_cnt++;
                    if (m_cnt >= DEB_FRAMES) m_accept();
                end else if (single) begin
                    m_cand = code; m_cnt = 1;
                end else begin
                    m_ph = M_IDLE; m_mcnt = 0;
                end
            end
            M_HELD: begin
                if (!match) begin
                    m_cnt = 1;
                    if (m_cnt >= DEB_FRAMES) m_drop();
                    else m_ph = M_REL;
                end
            end
            M_REL: begin
                if (match) m_ph = M_HELD;
                else begin
                    m_cnt++;
                    if (m_cnt >= DEB_FRAMES) m_drop();
                end
            end
        endcase
    endtask

    task automatic model_reset();
        m_ph = M_IDLE; m_cand = 15; m_cnt = 0; m_mcnt = 0;
        exp_b = 4'hF; exp_valid = 1'b0; exp_press = 1'b0;
        e = 0; acc_n = 0; acc_code = 15; pend = 0;
        exp_q.delete();
    endtask

    // One step per cycle: model the DUT after edge e, then compare.
    task automatic model_step();
        int          col;
        logic [11:0] k;
        logic [2:0]  exp_col;
        exp_press = 1'b0;
        if (pend) begin
            pend = 0;
            model_frame(fr_n, fr_code);
        end
        hist[e % 8] = keys;
        if (e > 0 && e % SCAN_DIV == 0) begin
            col = (e / SCAN_DIV - 1) % 3;
            k   = hist[(e - 3) % 8];   // synchronizer: rows seen 2 edges late
            for (int r = 0; r < 4; r++)
                if (k[r*3+col]) begin acc_n++; acc_code = key_tab[r*3+col]; end
            if (col == 2) begin
                fr_n = acc_n; fr_code = acc_code; pend = 1;
                acc_n = 0; acc_code = 15;
            end
        end
        exp_col = 3'b111;
        exp_col[(e / SCAN_DIV) % 3] = 1'b0;
        check_eq("col_out", 32'(COL_OUT), 32'(exp_col));
        check_eq("b_out", 32'(B_out), 32'(exp_b));
        check_eq("key_valid", 32'(KEY_VALID), 32'(exp_valid));
        check_eq("key_press", 32'(KEY_PRESS), 32'(exp_press));
        if (KEY_PRESS) begin
            press_cnt++;
            check_eq("press_code", 32'(B_out), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hF0);
        end
        if (!KEY_VALID) saw_low = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic run_cycle(input logic [11:0] k);
        @(posedge CLK);
        e++;
        #1 keys = k;
        @(negedge CLK);
        model_step();
    endtask

    task automatic hold(input logic [11:0] k, input int n);
        for (int i = 0; i < n; i++) run_cycle(k);
    endtask

    task automatic bounce(input logic [11:0] k, input int n, input int period);
        for (int i = 0; i < n; i++) run_cycle(((i / period) % 2 == 0) ? k : 12'h000);
    endtask

    task automatic apply_reset(input logic [11:0] k);
        @(negedge CLK);
        RST  = 1'b0;
        keys = k;
        #1;
        check_eq("rst_col", 32'(COL_OUT), 32'h6);
        check_eq("rst_b", 32'(B_out), 32'hF);
        check_eq("rst_valid", 32'(KEY_VALID), 32'h0);
        check_eq("rst_press", 32'(KEY_PRESS), 32'h0);
        repeat (3) @(negedge CLK);
        model_reset();
        hist[0] = keys;
        RST = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [11:0] rk;
        int          a, b, mode, len;
        model_reset();
        apply_reset(12'h000);

        // idle scan, then clean press of 5 and release
        hold(12'h000, 2 * FRAME);
        press_cnt = 0;
        hold(key_bit(5), 5 * FRAME);
        check_eq("clean_b", 32'(B_out), 32'd5);
        check_eq("clean_valid", 32'(KEY_VALID), 32'd1);
        check_eq("clean_pulses", 32'(press_cnt), 32'd1);
        hold(12'h000, 4 * FRAME);
        check_eq("clean_rel_b", 32'(B_out), 32'hF);
        check_eq("clean_rel_valid", 32'(KEY_VALID), 32'd0);

        // bouncing # then stable, then a one-frame dropout
        press_cnt = 0;
        bounce(key_bit(11), 2 * FRAME, 5);
        hold(key_bit(11), 5 * FRAME);
        check_eq("bounce_b", 32'(B_out), 32'd11);
        saw_low = 1'b0;
        hold(12'h000, FRAME);
        hold(key_bit(11), 3 * FRAME);
        check_eq("dropout_no_low", 32'(saw_low), 32'd0);
        check_eq("bounce_pulses", 32'(press_cnt), 32'd1);
        hold(12'h000, 4 * FRAME);

        // multi-key 1+9, then 0 alone
        hold(key_bit(1) | key_bit(9), 4 * FRAME);
        check_eq("multi_valid", 32'(KEY_VALID), 32'd0);
        check_eq("multi_b", 32'(B_out), 32'hF);
        hold(key_bit(0), 5 * FRAME);
        check_eq("zero_b", 32'(B_out), 32'd0);
        hold(12'h000, 4 * FRAME);

        // key change 2 -> *
        press_cnt = 0;
        hold(key_bit(2), 5 * FRAME);
        check_eq("change_b2", 32'(B_out), 32'd2);
        saw_low = 1'b0;
        hold(key_bit(10), 10 * FRAME);
        check_eq("change_gap", 32'(saw_low), 32'd1);
        check_eq("change_star", 32'(B_out), 32'd10);
        check_eq("change_pulses", 32'(press_cnt), 32'd2);
        hold(12'h000, 4 * FRAME);

        // randomized key activity
        for (int it = 0; it < 60; it++) begin
            mode = $urandom_range(0, 3);
            len  = $urandom_range(6, 70);
            a    = $urandom_range(0, 11);
            b    = (a + $urandom_range(1, 11)) % 12;
            rk   = '0;
            rk[a] = 1'b1;
            case (mode)
                0: hold(12'h000, len);
                1: hold(rk, len);
                2: begin rk[b] = 1'b1; hold(rk, len); end
                default: bounce(rk, len, $urandom_range(2, 7));
            endcase
        end
        hold(12'h000, 5 * FRAME);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a debounce (cnt=2 after two frames)
        apply_reset(key_bit(4));
        hold(key_bit(4), 2 * FRAME + 4);
        check_eq("middeb_valid", 32'(KEY_VALID), 32'd0);
        #2 RST = 1'b0;
        #1;
        check_eq("middeb_rst_col", 32'(COL_OUT), 32'h6);
        check_eq("middeb_rst_b", 32'(B_out), 32'hF);
        check_eq("middeb_rst_valid", 32'(KEY_VALID), 32'h0);
        check_eq("middeb_rst_press", 32'(KEY_PRESS), 32'h0);
        apply_reset(12'h000);
        hold(key_bit(4), 6 * FRAME);
        check_eq("after_rst_b", 32'(B_out), 32'd4);
        hold(12'h000, 4 * FRAME);

`ifdef KEYPAD_STICKY_EN
        hold(key_bit(7), 5 * FRAME);
        hold(12'h000, 5 * FRAME);
        check_eq("sticky_b", 32'(B_out), 32'd7);
        check_eq("sticky_valid", 32'(KEY_VALID), 32'd1);
        hold(key_bit(3) | key_bit(8), 5 * FRAME);
        check_eq("sticky_clear_b", 32'(B_out), 32'hF);
        check_eq("sticky_clear_valid", 32'(KEY_VALID), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
